ifmap_window_feeder: RTL and testbench

- Upstream stage of the PE ifmap scratchpad.
- Accepts a streamed ifmap row over a valid/ready handshake and writes it into the scratchpad as a circular buffer.
- Generates the sliding-window read sequence (FILT_LEN elements per window, advancing by a runtime stride) that feeds the PE MAC.
- Drives the scratchpad's ren/wen/r_addr/w_addr/din ports directly and tags the 1-cycle-late read data for the MAC.

---
 rtl/pe_pkg.sv | 23 ++
 rtl/circ_ptr.sv | 42 ++++
 rtl/ifmap_window_feeder.sv | 178 +++++++++++++++++
 tb/tb_ifmap_window_feeder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE ifmap feeder path.
// State encoding and wrap-around address arithmetic.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Operands are assumed already reduced, so one subtract suffices.
  function automatic logic [31:0] add_mod(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] size
  );
    logic [31:0] s;
    s = a + b;
    return (s >= size) ? s - size : s;
  endfunction

endpackage

// File: rtl/circ_ptr.sv
// Wrapping pointer over a SIZE-entry buffer with a variable step.
// Works for any SIZE, not only powers of two.
module circ_ptr
  import pe_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int AW   = 2,
  parameter int IW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [IW-1:0] inc_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = AW'(add_mod(32'(ptr_q),
                          32'(inc_i),
                          32'(SIZE)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ifmap_window_feeder.sv
// Streams an ifmap row into a circular scratchpad and replays it
// as overlapping FILT_LEN-element windows for the PE MAC.
module ifmap_window_feeder
  import pe_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int SIZE       = 4,
  parameter int FILT_LEN   = 3,
  parameter int ADDR_WIDTH = $clog2(SIZE),
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [CNT_WIDTH-1:0]  num_windows,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  spad_wen,
  output logic [ADDR_WIDTH-1:0] spad_w_addr,
  output logic [WIDTH-1:0]      spad_din,
  output logic                  spad_ren,
  output logic [ADDR_WIDTH-1:0] spad_r_addr,
  input  logic                  mac_ready,
  output logic                  rd_valid,
  output logic                  win_last,
  output logic                  done
);

  // Occupancy and stride must be able to hold SIZE itself.
  localparam int OW = $clog2(SIZE + 1);
  localparam int KW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  state_e state_q, state_d;

  logic [OW-1:0]        stride_q, stride_d, stride_c;
  logic [CNT_WIDTH-1:0] nwin_q, nwin_d;
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [KW-1:0]        k_q, k_d;
  logic [OW-1:0]        occ_q, occ_d;
  logic                 rdv_q, last_q;

  logic                  wr, rd, k_end;
  logic                  retire, last_win, clr;
  logic [ADDR_WIDTH-1:0] wptr, base;

  assign wr       = in_ready & in_valid;
  assign rd       = (state_q == RUN)
                  && (occ_q >= OW'(FILT_LEN))
                  && mac_ready;
  assign k_end    = (k_q == KW'(FILT_LEN - 1));
  assign retire   = rd & k_end;
  assign last_win = (wcnt_q == nwin_q - CNT_WIDTH'(1));
  assign clr      = (state_q == DONE);

  always_comb begin
    stride_c = OW'(stride);
    if (stride == '0) begin
      stride_c = OW'(1);
    end else if (32'(stride) > FILT_LEN) begin
      stride_c = OW'(FILT_LEN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_windows == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (retire && last_win) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == RUN) && (occ_q < OW'(SIZE));
    spad_wen    = wr;
    spad_w_addr = wptr;
    spad_din    = in_data;
    spad_ren    = rd;
    spad_r_addr = ADDR_WIDTH'(add_mod(32'(base),
                                      32'(k_q),
                                      32'(SIZE)));
    rd_valid    = rdv_q;
    win_last    = last_q;
    done        = (state_q == DONE);
  end

  always_comb begin
    stride_d = stride_q;
    nwin_d   = nwin_q;
    wcnt_d   = wcnt_q;
    k_d      = k_q;
    occ_d    = occ_q + OW'(wr)
             - (retire ? stride_q : '0);
    if (state_q == IDLE && start) begin
      stride_d = stride_c;
      nwin_d   = num_windows;
      wcnt_d   = '0;
    end
    if (rd) begin
      k_d = k_end ? '0 : k_q + KW'(1);
    end
    if (retire) begin
      wcnt_d = wcnt_q + CNT_WIDTH'(1);
    end
    if (clr) begin
      k_d    = '0;
      occ_d  = '0;
      wcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q <= OW'(1);
      nwin_q   <= '0;
      wcnt_q   <= '0;
      k_q      <= '0;
      occ_q    <= '0;
      rdv_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      stride_q <= stride_d;
      nwin_q   <= nwin_d;
      wcnt_q   <= wcnt_d;
      k_q      <= k_d;
      occ_q    <= occ_d;
      rdv_q    <= rd;
      last_q   <= retire;
    end
  end

  circ_ptr #(
    .SIZE (SIZE),
    .AW   (ADDR_WIDTH),
    .IW   (OW)
  ) u_wptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .en_i  (wr),
    .inc_i (OW'(1)),
    .ptr_o (wptr)
  );

  circ_ptr #(
    .SIZE (SIZE),
    .AW   (ADDR_WIDTH),
    .IW   (OW)
  ) u_base (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .en_i  (retire),
    .inc_i (stride_q),
    .ptr_o (base)
  );

endmodule

// File: tb/tb_ifmap_window_feeder.sv
// Randomized bench for ifmap_window_feeder with a stream-index
// window model and a small behavioural scratchpad.
module tb_ifmap_window_feeder;

  localparam int W  = 4;
  localparam int SZ = 4;
  localparam int FL = 3;
  localparam int AW = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready;
  logic          spad_wen, spad_ren, mac_ready;
  logic          rd_valid, win_last, done;
  logic [AW-1:0] stride, spad_w_addr, spad_r_addr;
  logic [CW-1:0] num_windows;
  logic [W-1:0]  in_data, spad_din, spad_dout;
  logic [W-1:0]  mem [SZ];

  int checks = 0;
  int errors = 0;
  int obs_q[$];
  int exp_q[$];
  logic [W-1:0] sent[$];
  int done_cnt, acc_at_hold, wen_full, stall_ren;
  int rdy_back, third_rd, first_waddr;

  ifmap_window_feeder #(
    .WIDTH(W), .SIZE(SZ), .FILT_LEN(FL),
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .stride(stride), .num_windows(num_windows),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .spad_wen(spad_wen),
    .spad_w_addr(spad_w_addr), .spad_din(spad_din),
    .spad_ren(spad_ren), .spad_r_addr(spad_r_addr),
    .mac_ready(mac_ready), .rd_valid(rd_valid),
    .win_last(win_last), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spad_wen) mem[spad_w_addr] <= spad_din;
    if (spad_ren) spad_dout <= mem[spad_r_addr];
  end

  // Window i, element j is stream element i*s+j, stored at (i*s+j) mod SIZE.
  task automatic model(input int str, input int nw);
    int s;
    int idx;
    s = (str == 0) ? 1 : ((str > FL) ? FL : str);
    exp_q.delete();
    for (int i = 0; i < nw; i++)
      for (int j = 0; j < FL; j++) begin
        idx = i * s + j;
        exp_q.push_back(((idx % SZ) << 8)
                        | (int'(sent[idx]) << 1)
                        | ((j == FL - 1) ? 1 : 0));
      end
  endtask

  task automatic run_job(input int str, input int nw,
                         input bit rnd_data, input bit rnd_mac,
                         input int hold, input int stall_at,
                         input int stall_len, input int bogus);
    int s, n, idx, cyc, post, stall_cnt;
    bit in_stall;
    int oaddr[$];
    int odat[$];
    s = (str == 0) ? 1 : ((str > FL) ? FL : str);
    n = (nw == 0) ? 0 : (nw - 1) * s + FL;
    idx = 0; cyc = 0; post = 0; stall_cnt = 0;
    sent.delete();
    for (int i = 0; i < n; i++)
      sent.push_back(rnd_data ? W'($urandom_range(0, 15)) : W'(i + 1));
    done_cnt = 0; acc_at_hold = -1; wen_full = 0; stall_ren = 0;
    rdy_back = -1; third_rd = -1; first_waddr = -1;
    @(negedge clk);
    start = 1'b1; stride = AW'(str); num_windows = CW'(nw);
    in_valid = 1'b0; mac_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 600 && !(done_cnt > 0 && post >= 3)) begin
      in_valid = (idx < n);
      in_data = (idx < n) ? sent[idx] : '0;
      mac_ready = rnd_mac ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc < hold) mac_ready = 1'b0;
      in_stall = 1'b0;
      if (stall_at >= 0 && oaddr.size() >= stall_at
          && stall_cnt < stall_len) begin
        mac_ready = 1'b0; in_stall = 1'b1; stall_cnt++;
      end
      start = (cyc == bogus);
      if (start) begin stride = 2'd2; num_windows = 8'd7; end
      #1;
      if (in_valid && in_ready) begin
        if (idx == 0) first_waddr = int'(spad_w_addr);
        idx++;
      end
      if (cyc == hold - 1) acc_at_hold = idx;
      if (cyc >= SZ && cyc < hold && spad_wen) wen_full++;
      if (spad_ren) begin
        if (oaddr.size() == FL - 1) third_rd = cyc;
        oaddr.push_back(int'(spad_r_addr));
        if (in_stall) stall_ren++;
      end
      if (hold > 0 && cyc >= hold && in_ready && rdy_back < 0)
        rdy_back = cyc;
      if (rd_valid)
        odat.push_back((int'(spad_dout) << 1) | (win_last ? 1 : 0));
      if (done) done_cnt++;
      if (done_cnt > 0) post++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; mac_ready = 1'b0; start = 1'b0;
    obs_q.delete();
    for (int i = 0; i < oaddr.size() || i < odat.size(); i++)
      obs_q.push_back((((i < oaddr.size()) ? oaddr[i] : 255) << 8)
                      | ((i < odat.size()) ? odat[i] : 255));
    model(str, nw);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      mac_ready = 1'($urandom_range(0, 1));
      in_data = W'($urandom_range(0, 15));
      stride = AW'($urandom_range(0, 3));
      num_windows = CW'($urandom_range(0, 9));
    end
    #1;
    checks++;
    if ({in_ready, spad_wen, spad_ren, rd_valid, win_last, done,
         spad_w_addr, spad_r_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {in_ready, spad_wen, spad_ren, rd_valid, win_last, done});
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || spad_wen !== 1'b0) begin
        errors++;
        $display("FAIL idle_in_ready: got %b/%b want 0/0",
                 in_ready, spad_wen);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    run_job(1, 3, 1'b0, 1'b0, 0, -1, 0, -1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_len: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_elem%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL basic_done: got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_stride();
    int strs[2] = '{2, 0};
    foreach (strs[t]) begin
      run_job(strs[t], 2, 1'b0, 1'b0, 0, -1, 0, -1);
      checks++;
      if (obs_q.size() != exp_q.size() || done_cnt != 1) begin
        errors++;
        $display("FAIL stride%0d_len: got %0d/%0d want %0d/1", strs[t],
                 obs_q.size(), done_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL stride%0d_elem%0d: got %h want %h",
                   strs[t], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int str, nw;
    for (int t = 0; t < 5; t++) begin
      str = $urandom_range(0, 3);
      nw = (t == 4) ? 0 : $urandom_range(1, 6);
      run_job(str, nw, 1'b1, 1'b1, 0, -1, 0, -1);
      checks++;
      if (obs_q.size() != exp_q.size() || done_cnt != 1) begin
        errors++;
        $display("FAIL rand%0d_len: got %0d/%0d want %0d/1 (s=%0d n=%0d)",
                 t, obs_q.size(), done_cnt, exp_q.size(), str, nw);
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_elem%0d: got %h want %h",
                   t, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    run_job(1, 3, 1'b1, 1'b0, 10, -1, 0, -1);
    checks++;
    if (acc_at_hold != SZ || wen_full != 0) begin
      errors++;
      $display("FAIL bp_full: got acc=%0d wen=%0d want %0d/0",
               acc_at_hold, wen_full, SZ);
    end
    checks++;
    if (third_rd < 0 || rdy_back != third_rd + 1) begin
      errors++;
      $display("FAIL bp_resume: got cyc %0d want %0d", rdy_back, third_rd + 1);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_elem%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    run_job(1, 3, 1'b1, 1'b0, 0, 2, 3, -1);
    checks++;
    if (stall_ren != 0 || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_reads: got ren=%0d len=%0d want 0/%0d",
               stall_ren, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_elem%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; stride = 2'd1; num_windows = 8'd3; mac_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      in_valid = 1'b1; in_data = W'($urandom_range(0, 15));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({in_ready, spad_wen, spad_ren, rd_valid, win_last, done,
         spad_w_addr, spad_r_addr} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got %b want 0",
               {in_ready, spad_wen, spad_ren, rd_valid, win_last, done});
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    run_job(1, 3, 1'b1, 1'b0, 0, -1, 0, 3);
    checks++;
    if (first_waddr != 0 || done_cnt != 1
        || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midrst_restart: got waddr=%0d done=%0d len=%0d want 0/1/%0d",
               first_waddr, done_cnt, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL midrst_elem%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; mac_ready = 1'b0;
    in_data = '0; stride = '0; num_windows = '0;
    test_reset();
    test_basic();
    test_stride();
    test_random();
    test_backpressure();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
